// File: rtl/fbuf_pkg.sv
// Shared widths, fill-engine state encoding and grant encoding for the
// framebuffer write path.
package fbuf_pkg;

  localparam int unsigned FBUF_ADDR_WIDTH = 19;
  localparam int unsigned FBUF_DATA_WIDTH = 8;
  localparam int unsigned DIM_WIDTH       = 10;

  typedef enum logic [1:0] {
    FILL_IDLE = 2'd0,
    FILL_RUN  = 2'd1,
    FILL_DONE = 2'd2
  } fill_state_e;

  typedef enum logic {
    GNT_PIX  = 1'b0,
    GNT_FILL = 1'b1
  } grant_e;

endpackage

// File: rtl/fbuf_fill_engine.sv
// Rectangle fill sequencer: walks a captured rectangle row by row and offers
// one write per cycle to the arbiter, advancing only when granted.
module fbuf_fill_engine #(
  parameter int unsigned FBUF_ADDR_WIDTH = fbuf_pkg::FBUF_ADDR_WIDTH,
  parameter int unsigned FBUF_DATA_WIDTH = fbuf_pkg::FBUF_DATA_WIDTH,
  parameter int unsigned DIM_WIDTH       = fbuf_pkg::DIM_WIDTH
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [FBUF_ADDR_WIDTH-1:0] base_i,
  input  logic [DIM_WIDTH-1:0]       width_i,
  input  logic [DIM_WIDTH-1:0]       height_i,
  input  logic [DIM_WIDTH-1:0]       stride_i,
  input  logic [FBUF_DATA_WIDTH-1:0] color_i,
  input  logic                       gnt_i,
  output logic                       req_o,
  output logic [FBUF_ADDR_WIDTH-1:0] addr_o,
  output logic [FBUF_DATA_WIDTH-1:0] data_o,
  output logic                       busy_o,
  output logic                       done_o
);
  import fbuf_pkg::*;

  fill_state_e                state_q;
  logic [DIM_WIDTH-1:0]       width_q;
  logic [DIM_WIDTH-1:0]       height_q;
  logic [DIM_WIDTH-1:0]       stride_q;
  logic [DIM_WIDTH-1:0]       x_q;
  logic [DIM_WIDTH-1:0]       y_q;
  logic [FBUF_ADDR_WIDTH-1:0] row_base_q;
  logic [FBUF_DATA_WIDTH-1:0] color_q;
  logic                       last_col;
  logic                       last_row;

  assign last_col = (x_q == width_q - DIM_WIDTH'(1));
  assign last_row = (y_q == height_q - DIM_WIDTH'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= FILL_IDLE;
      width_q    <= '0;
      height_q   <= '0;
      stride_q   <= '0;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      color_q    <= '0;
    end else begin
      case (state_q)
        FILL_IDLE: begin
          if (start_i) begin
            width_q    <= width_i;
            height_q   <= height_i;
            stride_q   <= stride_i;
            color_q    <= color_i;
            row_base_q <= base_i;
            x_q        <= '0;
            y_q        <= '0;
            // An empty rectangle still produces a completion pulse.
            state_q    <= ((width_i == '0) || (height_i == '0)) ? FILL_DONE : FILL_RUN;
          end
        end
        FILL_RUN: begin
          if (gnt_i) begin
            if (last_col) begin
              x_q        <= '0;
              y_q        <= y_q + DIM_WIDTH'(1);
              row_base_q <= row_base_q + FBUF_ADDR_WIDTH'(stride_q);
              if (last_row) begin
                state_q <= FILL_DONE;
              end
            end else begin
              x_q <= x_q + DIM_WIDTH'(1);
            end
          end
        end
        FILL_DONE: state_q <= FILL_IDLE;
        default:   state_q <= FILL_IDLE;
      endcase
    end
  end

  assign req_o  = (state_q == FILL_RUN);
  assign busy_o = (state_q != FILL_IDLE);
  assign done_o = (state_q == FILL_DONE);
  assign addr_o = row_base_q + FBUF_ADDR_WIDTH'(x_q);
  assign data_o = color_q;

endmodule

// File: rtl/fbuf_write_arbiter.sv
// Round-robin arbiter between the CPU pixel port and the rectangle fill
// engine, feeding a single registered framebuffer BRAM write port.
module fbuf_write_arbiter #(
  parameter int unsigned FBUF_ADDR_WIDTH = fbuf_pkg::FBUF_ADDR_WIDTH,
  parameter int unsigned FBUF_DATA_WIDTH = fbuf_pkg::FBUF_DATA_WIDTH,
  parameter int unsigned DIM_WIDTH       = fbuf_pkg::DIM_WIDTH
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  input  logic [FBUF_ADDR_WIDTH-1:0] pix_addr,
  input  logic [FBUF_DATA_WIDTH-1:0] pix_data,
  input  logic                       fill_start,
  input  logic [FBUF_ADDR_WIDTH-1:0] fill_base,
  input  logic [DIM_WIDTH-1:0]       fill_width,
  input  logic [DIM_WIDTH-1:0]       fill_height,
  input  logic [DIM_WIDTH-1:0]       fill_stride,
  input  logic [FBUF_DATA_WIDTH-1:0] fill_color,
  output logic                       fill_busy,
  output logic                       fill_done,
  output logic                       fbuf_en_wr,
  output logic                       fbuf_wrea,
  output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
  output logic [FBUF_DATA_WIDTH-1:0] fbuf_data
);
  import fbuf_pkg::*;

  logic                       eng_req;
  logic [FBUF_ADDR_WIDTH-1:0] eng_addr;
  logic [FBUF_DATA_WIDTH-1:0] eng_data;
  logic                       eng_busy;
  logic                       eng_done;

  logic                       pix_req;
  logic                       fill_req;
  logic                       pix_gnt;
  logic                       fill_gnt;

  grant_e                     last_grant_q, last_grant_d;
  logic                       wr_en_q, wr_en_d;
  logic [FBUF_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [FBUF_DATA_WIDTH-1:0] data_q, data_d;

  fbuf_fill_engine #(
    .FBUF_ADDR_WIDTH (FBUF_ADDR_WIDTH),
    .FBUF_DATA_WIDTH (FBUF_DATA_WIDTH),
    .DIM_WIDTH       (DIM_WIDTH)
  ) u_fill (
    .clk_i    (aclk),
    .rst_i    (areset),
    .start_i  (fill_start),
    .base_i   (fill_base),
    .width_i  (fill_width),
    .height_i (fill_height),
    .stride_i (fill_stride),
    .color_i  (fill_color),
    .gnt_i    (fill_gnt),
    .req_o    (eng_req),
    .addr_o   (eng_addr),
    .data_o   (eng_data),
    .busy_o   (eng_busy),
    .done_o   (eng_done)
  );

  always_comb begin
    pix_req  = pix_valid & ~areset;
    fill_req = eng_req & ~areset;
    // Under contention the pixel port wins only if the fill engine won last.
    pix_gnt  = pix_req & (~fill_req | (last_grant_q == GNT_FILL));
    fill_gnt = fill_req & ~pix_gnt;

    last_grant_d = last_grant_q;
    wr_en_d      = pix_gnt | fill_gnt;
    addr_d       = '0;
    data_d       = '0;
    if (pix_gnt) begin
      last_grant_d = GNT_PIX;
      addr_d       = pix_addr;
      data_d       = pix_data;
    end else if (fill_gnt) begin
      last_grant_d = GNT_FILL;
      addr_d       = eng_addr;
      data_d       = eng_data;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      last_grant_q <= GNT_FILL;
      wr_en_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

  // Outputs are masked while areset is high so a pending write is dropped
  // in the reset cycle itself rather than one cycle later.
  assign pix_ready  = pix_gnt;
  assign fill_busy  = eng_busy & ~areset;
  assign fill_done  = eng_done & ~areset;
  assign fbuf_en_wr = wr_en_q & ~areset;
  assign fbuf_wrea  = wr_en_q & ~areset;
  assign fbuf_addr  = areset ? '0 : addr_q;
  assign fbuf_data  = areset ? '0 : data_q;

endmodule

// File: tb/tb_fbuf_write_arbiter.sv
// Self-checking bench for fbuf_write_arbiter: directed and randomized
// pixel/fill traffic against a rectangle-walk reference model.
`timescale 1ns/1ps
module tb_fbuf_write_arbiter;
  localparam int AW = 19;
  localparam int DW = 8;
  localparam int WW = 10;

  logic          aclk;
  logic          areset;
  logic          pix_valid;
  logic          pix_ready;
  logic [AW-1:0] pix_addr;
  logic [DW-1:0] pix_data;
  logic          fill_start;
  logic [AW-1:0] fill_base;
  logic [WW-1:0] fill_width;
  logic [WW-1:0] fill_height;
  logic [WW-1:0] fill_stride;
  logic [DW-1:0] fill_color;
  logic          fill_busy;
  logic          fill_done;
  logic          fbuf_en_wr;
  logic          fbuf_wrea;
  logic [AW-1:0] fbuf_addr;
  logic [DW-1:0] fbuf_data;

  fbuf_write_arbiter #(
    .FBUF_ADDR_WIDTH (AW),
    .FBUF_DATA_WIDTH (DW),
    .DIM_WIDTH       (WW)
  ) dut (
    .aclk        (aclk),
    .areset      (areset),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_addr    (pix_addr),
    .pix_data    (pix_data),
    .fill_start  (fill_start),
    .fill_base   (fill_base),
    .fill_width  (fill_width),
    .fill_height (fill_height),
    .fill_stride (fill_stride),
    .fill_color  (fill_color),
    .fill_busy   (fill_busy),
    .fill_done   (fill_done),
    .fbuf_en_wr  (fbuf_en_wr),
    .fbuf_wrea   (fbuf_wrea),
    .fbuf_addr   (fbuf_addr),
    .fbuf_data   (fbuf_data)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int unsigned   c;
  } wr_t;

  wr_t           wr_log[$];
  int unsigned   done_log[$];
  int unsigned   busy_cnt = 0;
  logic [AW-1:0] exp_a[$];

  always @(negedge aclk) begin
    cyc++;
    if (fbuf_en_wr) wr_log.push_back('{a: fbuf_addr, d: fbuf_data, c: cyc});
    if (fill_done) done_log.push_back(cyc);
    if (fill_busy) busy_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic clear_logs();
    tick(1);
    wr_log.delete();
    done_log.delete();
    busy_cnt = 0;
  endtask

  task automatic do_reset();
    areset = 1'b1; pix_valid = 1'b0; fill_start = 1'b0;
    tick(2);
    areset = 1'b0;
  endtask

  task automatic start_fill(input logic [AW-1:0] b, input int w, input int h,
                            input int s, input logic [DW-1:0] c);
    fill_base = b; fill_width = WW'(w); fill_height = WW'(h);
    fill_stride = WW'(s); fill_color = c; fill_start = 1'b1;
    tick(1);
    fill_start = 1'b0;
  endtask

  task automatic wait_fill_end(input bit scramble);
    bit ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge aclk); #1;
      if (!fill_busy) begin ok = 1'b1; break; end
      if (scramble) begin
        fill_base = AW'($urandom); fill_width = WW'($urandom);
        fill_height = WW'($urandom); fill_stride = WW'($urandom);
        fill_color = DW'($urandom);
      end
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL fill_timeout: busy=%b required 0", fill_busy); end
  endtask

  // Reference: every pixel of the rectangle, row-major, address taken mod 2^AW.
  function automatic void build_exp(input logic [AW-1:0] b, input int w, input int h, input int s);
    exp_a.delete();
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        exp_a.push_back(AW'(int'(b) + y * s + x));
  endfunction

  task automatic test_reset();
    areset = 1'b1; pix_valid = 1'b1; pix_addr = 'h123; pix_data = 'h5A;
    fill_start = 1'b1; fill_base = 'h10; fill_width = 3; fill_height = 2;
    fill_stride = 8; fill_color = 'h77;
    for (int i = 0; i < 2; i++) begin
      @(negedge aclk);
      n_cmp++;
      if ({pix_ready, fbuf_en_wr, fbuf_wrea, fill_busy, fill_done} !== 5'b0 ||
          fbuf_addr !== '0 || fbuf_data !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs: rdy=%b en=%b wrea=%b busy=%b done=%b addr=%h data=%h required all 0",
                 pix_ready, fbuf_en_wr, fbuf_wrea, fill_busy, fill_done, fbuf_addr, fbuf_data);
      end
      tick(1);
    end
    pix_valid = 1'b0; fill_start = 1'b0;
    tick(1);
    areset = 1'b0;
    @(negedge aclk);
    n_cmp++;
    if (fill_busy !== 1'b0 || fbuf_en_wr !== 1'b0) begin
      n_bad++; $display("FAIL reset_idle: busy=%b en=%b required 0/0", fill_busy, fbuf_en_wr);
    end
  endtask

  task automatic test_pixel_only();
    bit            pv = 1'b0;
    logic [AW-1:0] pa = '0;
    logic [DW-1:0] pd = '0;
    tick(1);
    pix_valid = 1'b1; pix_addr = 'h00010; pix_data = 'hA5;
    @(negedge aclk);
    n_cmp++;
    if (pix_ready !== 1'b1) begin n_bad++; $display("FAIL pix_ready: got %b required 1", pix_ready); end
    @(posedge aclk); #1;
    pix_valid = 1'b0;
    @(negedge aclk);
    n_cmp++;
    if (fbuf_en_wr !== 1'b1 || fbuf_wrea !== 1'b1 || fbuf_addr !== 19'h00010 || fbuf_data !== 8'hA5) begin
      n_bad++;
      $display("FAIL pix_write: en=%b wrea=%b addr=%h data=%h required 1 1 00010 a5",
               fbuf_en_wr, fbuf_wrea, fbuf_addr, fbuf_data);
    end
    repeat (40) begin
      @(posedge aclk); #1;
      pix_valid = 1'($urandom_range(0, 1));
      pix_addr  = AW'($urandom);
      pix_data  = DW'($urandom);
      @(negedge aclk);
      n_cmp++;
      if (pix_ready !== pix_valid) begin
        n_bad++; $display("FAIL pix_rand_ready: got %b required %b", pix_ready, pix_valid);
      end
      n_cmp++;
      if (pv && (fbuf_en_wr !== 1'b1 || fbuf_wrea !== 1'b1 || fbuf_addr !== pa || fbuf_data !== pd)) begin
        n_bad++; $display("FAIL pix_rand_write: en=%b addr=%h data=%h required 1 %h %h",
                          fbuf_en_wr, fbuf_addr, fbuf_data, pa, pd);
      end else if (!pv && (fbuf_en_wr !== 1'b0 || fbuf_wrea !== 1'b0 || fbuf_addr !== '0 || fbuf_data !== '0)) begin
        n_bad++; $display("FAIL idle_zero: en=%b wrea=%b addr=%h data=%h required all 0",
                          fbuf_en_wr, fbuf_wrea, fbuf_addr, fbuf_data);
      end
      pv = pix_valid; pa = pix_addr; pd = pix_data;
    end
    @(posedge aclk); #1;
    pix_valid = 1'b0;
    tick(2);
  endtask

  task automatic test_fill_only();
    clear_logs();
    start_fill(19'd100, 3, 2, 640, 8'h3C);
    wait_fill_end(1'b0);
    build_exp(19'd100, 3, 2, 640);
    n_cmp++;
    if (wr_log.size() != exp_a.size()) begin
      n_bad++; $display("FAIL fill_count: got %0d required %0d", wr_log.size(), exp_a.size());
    end
    foreach (exp_a[i]) if (i < int'(wr_log.size())) begin
      n_cmp++;
      if (wr_log[i].a !== exp_a[i] || wr_log[i].d !== 8'h3C || wr_log[i].c != wr_log[0].c + i) begin
        n_bad++; $display("FAIL fill_write[%0d]: got %h/%h cyc+%0d required %h/3c cyc+%0d",
                          i, wr_log[i].a, wr_log[i].d, wr_log[i].c - wr_log[0].c, exp_a[i], i);
      end
    end
    n_cmp++;
    if (done_log.size() != 1 || wr_log.size() == 0 || done_log[0] != wr_log[wr_log.size()-1].c) begin
      n_bad++; $display("FAIL fill_done_timing: pulses=%0d required 1 aligned with last write", done_log.size());
    end
    n_cmp++;
    if (busy_cnt != 7) begin n_bad++; $display("FAIL fill_busy_len: got %0d required 7", busy_cnt); end
  endtask

  task automatic test_zero_size();
    clear_logs();
    start_fill(19'h00400, 0, 5, 10, 8'hFF);
    wait_fill_end(1'b0);
    n_cmp++;
    if (wr_log.size() != 0 || busy_cnt != 1 || done_log.size() != 1) begin
      n_bad++; $display("FAIL zero_size: writes=%0d busy=%0d done=%0d required 0/1/1",
                        wr_log.size(), busy_cnt, done_log.size());
    end
  endtask

  task automatic test_contention();
    bit ok = 1'b0;
    int nfill = 0;
    do_reset();
    clear_logs();
    pix_addr = 'h05000; pix_data = 'h11;
    start_fill(19'h00300, 4, 1, 1, 8'h22);
    pix_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge aclk); #1;
      if (done_log.size() != 0) begin ok = 1'b1; break; end
    end
    @(posedge aclk); #1;
    pix_valid = 1'b0;
    tick(2);
    n_cmp++;
    if (!ok || wr_log.size() < 8) begin
      n_bad++; $display("FAIL contention_len: writes=%0d done=%b required >=8 and done", wr_log.size(), ok);
    end
    for (int i = 0; i < 8 && i < int'(wr_log.size()); i++) begin
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      ea = (i % 2 == 0) ? 19'h05000 : AW'(19'h00300 + i / 2);
      ed = (i % 2 == 0) ? 8'h11 : 8'h22;
      n_cmp++;
      if (wr_log[i].a !== ea || wr_log[i].d !== ed || wr_log[i].c != wr_log[0].c + i) begin
        n_bad++; $display("FAIL contention[%0d]: got %h/%h required %h/%h", i, wr_log[i].a, wr_log[i].d, ea, ed);
      end
    end
    foreach (wr_log[i]) if (wr_log[i].d == 8'h22) nfill++;
    n_cmp++;
    if (nfill != 4) begin n_bad++; $display("FAIL contention_fill_count: got %0d required 4", nfill); end
  endtask

  task automatic test_wrap_abort();
    bit ok = 1'b0;
    clear_logs();
    start_fill(19'h7FFFE, 4, 1, 7, 8'h9E);
    wait_fill_end(1'b0);
    build_exp(19'h7FFFE, 4, 1, 7);
    n_cmp++;
    if (wr_log.size() != 4) begin n_bad++; $display("FAIL wrap_count: got %0d required 4", wr_log.size()); end
    foreach (exp_a[i]) if (i < int'(wr_log.size())) begin
      n_cmp++;
      if (wr_log[i].a !== exp_a[i] || wr_log[i].d !== 8'h9E) begin
        n_bad++; $display("FAIL wrap_write[%0d]: got %h/%h required %h/9e", i, wr_log[i].a, wr_log[i].d, exp_a[i]);
      end
    end
    clear_logs();
    start_fill(19'h7FFFE, 4, 1, 7, 8'h9E);
    for (int k = 0; k < 100; k++) begin
      @(negedge aclk); #1;
      if (wr_log.size() >= 2) begin ok = 1'b1; break; end
    end
    @(posedge aclk); #1;
    areset = 1'b1;
    @(negedge aclk);
    n_cmp++;
    if (!ok || {pix_ready, fbuf_en_wr, fbuf_wrea, fill_busy, fill_done} !== 5'b0 ||
        fbuf_addr !== '0 || fbuf_data !== '0) begin
      n_bad++; $display("FAIL abort_outputs: reached=%b en=%b busy=%b done=%b addr=%h required 1 and all 0",
                        ok, fbuf_en_wr, fill_busy, fill_done, fbuf_addr);
    end
    @(posedge aclk); #1;
    areset = 1'b0;
    tick(3);
    n_cmp++;
    if (wr_log.size() != 2 || done_log.size() != 0 || fill_busy !== 1'b0) begin
      n_bad++; $display("FAIL abort_state: writes=%0d done=%0d busy=%b required 2/0/0",
                        wr_log.size(), done_log.size(), fill_busy);
    end
    clear_logs();
    start_fill(19'h00200, 2, 2, 16, 8'h77);
    wait_fill_end(1'b0);
    build_exp(19'h00200, 2, 2, 16);
    n_cmp++;
    if (wr_log.size() != 4 || done_log.size() != 1) begin
      n_bad++; $display("FAIL restart: writes=%0d done=%0d required 4/1", wr_log.size(), done_log.size());
    end
    foreach (exp_a[i]) if (i < int'(wr_log.size())) begin
      n_cmp++;
      if (wr_log[i].a !== exp_a[i] || wr_log[i].d !== 8'h77) begin
        n_bad++; $display("FAIL restart_write[%0d]: got %h/%h required %h/77", i, wr_log[i].a, wr_log[i].d, exp_a[i]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    clear_logs();
    start_fill(19'd50, 3, 2, 20, 8'h44);
    tick(2);
    fill_base = 19'd900; fill_width = 5; fill_height = 5; fill_stride = 3; fill_color = 8'hEE;
    fill_start = 1'b1;
    tick(1);
    fill_start = 1'b0;
    wait_fill_end(1'b0);
    build_exp(19'd50, 3, 2, 20);
    n_cmp++;
    if (wr_log.size() != exp_a.size() || done_log.size() != 1) begin
      n_bad++; $display("FAIL busy_start_count: writes=%0d done=%0d required %0d/1",
                        wr_log.size(), done_log.size(), exp_a.size());
    end
    foreach (exp_a[i]) if (i < int'(wr_log.size())) begin
      n_cmp++;
      if (wr_log[i].a !== exp_a[i] || wr_log[i].d !== 8'h44) begin
        n_bad++; $display("FAIL busy_start_write[%0d]: got %h/%h required %h/44", i, wr_log[i].a, wr_log[i].d, exp_a[i]);
      end
    end
  endtask

  task automatic test_random_fill();
    repeat (8) begin
      logic [AW-1:0] b;
      logic [DW-1:0] c;
      int w, h, s;
      b = AW'($urandom); c = DW'($urandom);
      w = int'($urandom_range(0, 5)); h = int'($urandom_range(0, 4)); s = int'($urandom_range(0, 1023));
      clear_logs();
      start_fill(b, w, h, s, c);
      wait_fill_end(1'b1);
      build_exp(b, w, h, s);
      n_cmp++;
      if (wr_log.size() != exp_a.size() || done_log.size() != 1 || busy_cnt != w * h + 1) begin
        n_bad++; $display("FAIL rand_fill %0dx%0d: writes=%0d done=%0d busy=%0d required %0d/1/%0d",
                          w, h, wr_log.size(), done_log.size(), busy_cnt, exp_a.size(), w * h + 1);
      end
      foreach (exp_a[i]) if (i < int'(wr_log.size())) begin
        n_cmp++;
        if (wr_log[i].a !== exp_a[i] || wr_log[i].d !== c) begin
          n_bad++; $display("FAIL rand_write[%0d]: got %h/%h required %h/%h", i, wr_log[i].a, wr_log[i].d, exp_a[i], c);
        end
      end
    end
  endtask

  initial begin
    areset = 1'b1; pix_valid = 1'b0; pix_addr = '0; pix_data = '0;
    fill_start = 1'b0; fill_base = '0; fill_width = '0; fill_height = '0;
    fill_stride = '0; fill_color = '0;
    tick(1);
    test_reset();
    test_pixel_only();
    test_fill_only();
    test_zero_size();
    test_contention();
    test_wrap_abort();
    test_start_while_busy();
    test_random_fill();
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fbuf_write_arbiter.md
FBUF_WRITE_ARBITER -- requirements
Module: fbuf_write_arbiter

Interface
REQ-001 Parameters SHALL be: FBUF_ADDR_WIDTH, default 19, framebuffer word-address width; FBUF_DATA_WIDTH, default 8, pixel width; DIM_WIDTH, default 10, width of fill dimension and stride fields.
REQ-002 aclk  in  1  sole clock; all logic on the rising edge.
REQ-003 areset  in  1  synchronous, active-high reset.
REQ-004 pix_valid  in  1  pixel-write request from the CPU register path.
REQ-005 pix_ready  out  1  pixel write accepted this cycle.
REQ-006 pix_addr  in  FBUF_ADDR_WIDTH  pixel word address.
REQ-007 pix_data  in  FBUF_DATA_WIDTH  pixel value.
REQ-008 fill_start  in  1  single-cycle pulse that starts a rectangle fill.
REQ-009 fill_base  in  FBUF_ADDR_WIDTH  address of the top-left pixel.
REQ-010 fill_width, fill_height, fill_stride  in  DIM_WIDTH each  rectangle size in pixels and row pitch in words.
REQ-011 fill_color  in  FBUF_DATA_WIDTH  fill value.
REQ-012 fill_busy  out  1  fill in progress.
REQ-013 fill_done  out  1  single-cycle completion pulse.
REQ-014 fbuf_en_wr, fbuf_wrea  out  1 each; fbuf_addr  out  FBUF_ADDR_WIDTH; fbuf_data  out  FBUF_DATA_WIDTH: framebuffer BRAM write port.

Function
REQ-015 The block SHALL issue at most one BRAM write per cycle.
REQ-016 A pixel handshake (pix_valid && pix_ready) or a fill-engine grant SHALL produce a BRAM write on the following cycle: fbuf_en_wr=fbuf_wrea=1, with the registered address and data of that write.
REQ-017 In cycles with no write, fbuf_en_wr, fbuf_wrea, fbuf_addr and fbuf_data SHALL all be 0.
REQ-018 pix_ready SHALL be combinational, and SHALL be 1 only when areset=0, pix_valid=1 and the pixel port holds the grant.
REQ-019 Arbitration with a single requester: that requester wins.
REQ-020 Arbitration when both the pixel port and the fill engine request: round-robin; the winner is the requester not granted last; a last_grant register updates on every grant.
REQ-021 After reset, last_grant SHALL be "fill", so the pixel port wins the first contention.
REQ-022 The fill engine SHALL have states IDLE, RUN and DONE.
REQ-023 IDLE: fill_start captures base, width, height, stride and color. The engine goes to RUN, or directly to DONE if width=0 or height=0, in which case it issues no writes.
REQ-024 RUN: the engine requests every cycle and advances x only when granted. The address is row_base+x, computed modulo 2^FBUF_ADDR_WIDTH.
REQ-025 End of row (x=width-1, granted): x resets to 0, row_base advances by stride (wrapping modulo 2^FBUF_ADDR_WIDTH) and y increments.
REQ-026 Last pixel (x=width-1, y=height-1, granted): the engine goes to DONE.
REQ-027 DONE: fill_done=1 for exactly one cycle, then IDLE.
REQ-028 fill_busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-029 fill_start outside IDLE SHALL be ignored.
REQ-030 Input changes during RUN SHALL NOT affect the fill, because the parameters are captured at start.
REQ-031 Total fill writes SHALL equal width*height.
REQ-032 Fill rows SHALL be written in ascending address order, left to right then top to bottom.

Reset
REQ-033 areset SHALL force the fill engine to IDLE, clear x, y and row_base, and set last_grant to "fill".
REQ-034 areset SHALL drive every output to 0 in the same cycle; pix_ready SHALL be gated combinationally.
REQ-035 Reset during RUN SHALL abort the fill with no fill_done pulse; a write already registered in the BRAM output stage SHALL be dropped.

Structure
REQ-036 Shared package fbuf_pkg SHALL hold FBUF_ADDR_WIDTH, FBUF_DATA_WIDTH, DIM_WIDTH defaults, the fill state enumeration (IDLE/RUN/DONE) and grant encoding constants.
REQ-037 The rectangle sequencer SHALL be a sub-module, fbuf_fill_engine, with a req/grant/addr/data interface toward the arbiter.
REQ-038 The arbiter and the BRAM output register stage SHALL live in fbuf_write_arbiter.

Verification
REQ-039 Pixel only: pix_valid=1, addr=0x00010, data=0xA5, fill idle. Required response: pix_ready=1 in the same cycle, and the next cycle shows fbuf_en_wr=1, addr=0x00010, data=0xA5.
REQ-040 Fill only: base=100, width=3, height=2, stride=640, color=0x3C. Required response: writes to 100, 101, 102, 740, 741, 742 on 6 consecutive cycles, then fill_done one cycle after the last grant, with fill_busy high throughout.
REQ-041 Contention: pix_valid held high with a 4x1 fill running. Required response: grants alternate pix, fill, pix, fill, and the pixel port is granted first after reset.
REQ-042 Zero size: width=0, height=5. Required response: no fbuf writes, fill_busy high for 1 cycle, fill_done pulse.
REQ-043 Wrap and abort: base=0x7FFFE, width=4, height=1. Required response: writes to 0x7FFFE, 0x7FFFF, 0x00000, 0x00001. A second run asserts areset after 2 writes; required response: all outputs 0 next cycle, no fill_done, and a new fill_start is accepted.
REQ-044 Start while busy: fill_start during RUN with different parameters. Required response: ignored, and the original write sequence is unchanged.
